hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Keeps a shadow scoreboard of destination register and Tnew for the E, M and W stages.
- From that scoreboard it generates the D-stage operand source selects (Sign_RD1Src/Sign_RD2Src), the E-stage ALU forward selects, and the stall/bubble controls.
- Also tracks mult/div unit occupancy and stalls HI/LO-dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issue.
- DIV_CYCLES, 10, busy cycles after div/divu issue.
- CNT_W, 4, width of the md busy counter; must hold DIV_CYCLES.

Ports:
- clk in 1 — system clock, rising edge.
- reset in 1 — synchronous, active-low reset.
- d_rs in 5 — rs field of the instruction in D.
- d_rt in 5 — rt field of the instruction in D.
- d_tuse_rs in 2 — cycles until D instruction needs rs (0 = in D, 1 = in E, 3 = unused).
- d_tuse_rt in 2 — same for rt.
- d_dst in 5 — destination register of D instruction; 0 = none.
- d_tnew in 2 — cycles from E entry until the result is available.
- d_is_md in 1 — D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_e in 1 — E stage issues mult/div this cycle.
- md_is_div in 1 — qualifies md_start_e: 1 = div, 0 = mult.
- stall out 1 — freeze PC and IF/ID register.
- bubble_e out 1 — clear the ID/EX register (equal to stall).
- sign_rd1src out 2 — D rs source: 0 GRF, 1 E, 2 M, 3 zero.
- sign_rd2src out 2 — same encoding for rt.
- fwd_rs_e out 2 — E rs source: 0 none, 1 M, 2 W.
- fwd_rt_e out 2 — same encoding for rt.
- stall_cnt out 32 — only with the optional feature.
- md_stall_cnt out 32 — only with the optional feature.

Behaviour:
- Shadow state: E, M and W slots, each holding {rs, rt, dst, tnew}. The W slot holds only {dst}.
- Reset:
  - reset==0 at posedge clears all slots to 0 and the md counter to 0.
  - All outputs then read 0 (sign_*src reads 3 when the D address is 0).
- Advance every posedge while reset==1:
  - If !stall: E <= {d_rs, d_rt, d_dst, d_tnew}.
  - If stall: E <= 0 (bubble).
  - M <= {E.rs, E.rt, E.dst, sat(E.tnew-1)}, where sat clamps at 0.
  - W.dst <= M.dst.
- Stall (combinational), for each used source s (tuse != 3, addr != 0):
  - stall_s = (E.dst==s && d_tuse < E.tnew) || (M.dst==s && d_tuse < M.tnew).
  - stall = stall_rs | stall_rt | md_stall.
- D selects (combinational), for address a:
  - a==0 → 3.
  - else E.dst==a && E.tnew==0 → 1.
  - else M.dst==a && M.tnew==0 → 2.
  - else 0; GRF write-through covers W.
  - E has priority over M.
- E forwards:
  - E.rs!=0 && M.dst==E.rs && M.tnew==0 → 1.
  - else W.dst==E.rs → 2.
  - else 0.
  - Same for rt.
- md counter:
  - At posedge, if md_start_e: cnt <= md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - Else if cnt != 0: cnt <= cnt-1.
  - md_busy = md_start_e || cnt != 0.
  - md_stall = d_is_md && md_busy.
- Simultaneous events:
  - Reset wins over all updates.
  - md_start_e while cnt != 0 reloads the counter; not expected, since D already stalled.
- Output latency: all outputs are combinational from the current state and D inputs. State changes are visible one cycle after the triggering edge.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with stall==1.
  - md_stall_cnt increments on each cycle with md_stall==1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared constants header (existing constant.v):
  - FWD_D_GRF/E/M/ZERO = 0/1/2/3.
  - FWD_E_NONE/M/W = 0/1/2.
  - TUSE_NONE = 3.
- One sub-module: md_busy_ctr (counter, md_busy output).

Test Plan:
- addu $1 in E (tnew 1); D = beq rs=$1, tuse 0 → stall=1 one cycle. Next cycle: addu in M with tnew 0, stall=0, sign_rd1src=2.
- lw $1 in E (tnew 2); D = addu $2,$1,$3 (tuse_rs 1):
  - cycle 1: stall=1.
  - cycle 2: lw in M tnew 1, stall=0, sign_rd1src=0.
  - cycle 3: addu in E, lw in W, fwd_rs_e=2.
- jal in E (dst 31, tnew 0); D reads rs=$31 tuse 0 → stall=0, sign_rd1src=1. Same with d_rs=0 → sign_rd1src=3, stall=0.
- md_start_e with md_is_div=1, then D = mflo → stall=1 for 11 cycles (start cycle + 10), then 0. Mult case: 6 cycles.
- reset=0 for one edge during div busy (cnt=7) → next cycle cnt=0, stall=0, all slots 0. With HAZARD_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, slot type and scoreboard helpers for the hazard controller.
package hazard_ctrl_pkg;

    // D-stage operand source selects
    localparam logic [1:0] FWD_D_GRF  = 2'd0;
    localparam logic [1:0] FWD_D_E    = 2'd1;
    localparam logic [1:0] FWD_D_M    = 2'd2;
    localparam logic [1:0] FWD_D_ZERO = 2'd3;

    // E-stage ALU operand forward selects
    localparam logic [1:0] FWD_E_NONE = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    localparam logic [1:0] TUSE_NONE  = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
    } e_slot_t;

    // rs/rt of the instruction in M are never consulted, so only dst/tnew are kept.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_slot_t;

    // Tnew counts down by one per stage and saturates at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A D-stage source stalls when a producer in E or M is still too far from its result.
    function automatic logic src_stall(input logic [4:0] a, input logic [1:0] tuse,
                                       input e_slot_t e, input m_slot_t m);
        if (tuse == TUSE_NONE || a == 5'd0) return 1'b0;
        return (e.dst == a && tuse < e.tnew) || (m.dst == a && tuse < m.tnew);
    endfunction

    // D-stage source select; the younger producer in E wins over M.
    function automatic logic [1:0] d_sel(input logic [4:0] a, input e_slot_t e, input m_slot_t m);
        if (a == 5'd0)                      return FWD_D_ZERO;
        if (e.dst == a && e.tnew == 2'd0)   return FWD_D_E;
        if (m.dst == a && m.tnew == 2'd0)   return FWD_D_M;
        return FWD_D_GRF;
    endfunction

    // E-stage forward select; $0 is never forwarded.
    function automatic logic [1:0] e_fwd(input logic [4:0] a, input m_slot_t m, input logic [4:0] w_dst);
        if (a == 5'd0)                      return FWD_E_NONE;
        if (m.dst == a && m.tnew == 2'd0)   return FWD_E_M;
        if (w_dst == a)                     return FWD_E_W;
        return FWD_E_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Mult/div unit occupancy counter: loads on issue, counts down to idle.
module md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Reload on issue (even if still busy), otherwise drain toward zero.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else if (md_start_e)
            cnt_q <= md_is_div ? DIV_LD : MULT_LD;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    // The issue cycle itself already counts as busy.
    assign md_busy = md_start_e || (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: shadow E/M/W scoreboard,
// D/E forward selects, stall/bubble and mult/div occupancy stall.
// Optional: HAZARD_PERF_EN adds stall_cnt / md_stall_cnt performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_dst,
    input  logic [1:0]  d_tnew,
    input  logic        d_is_md,
    input  logic        md_start_e,
    input  logic        md_is_div,
    output logic        stall,
    output logic        bubble_e,
    output logic [1:0]  sign_rd1src,
    output logic [1:0]  sign_rd2src,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
);

    e_slot_t    e_q;
    m_slot_t    m_q;
    logic [4:0] w_dst_q;
    logic       md_busy;
    logic       md_stall;

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_ctr (
        .clk       (clk),
        .reset     (reset),
        .md_start_e(md_start_e),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // Stall and select decode from the scoreboard and the D-stage fields.
    always_comb begin
        md_stall    = d_is_md && md_busy;
        stall       = src_stall(d_rs, d_tuse_rs, e_q, m_q)
                    | src_stall(d_rt, d_tuse_rt, e_q, m_q)
                    | md_stall;
        bubble_e    = stall;
        sign_rd1src = d_sel(d_rs, e_q, m_q);
        sign_rd2src = d_sel(d_rt, e_q, m_q);
        fwd_rs_e    = e_fwd(e_q.rs, m_q, w_dst_q);
        fwd_rt_e    = e_fwd(e_q.rt, m_q, w_dst_q);
    end

    // Scoreboard advance; a stalled D instruction leaves a bubble in E.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= '0;
        end else begin
            e_q     <= stall ? '0 : e_slot_t'{rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew};
            m_q     <= m_slot_t'{dst: e_q.dst, tnew: tnew_dec(e_q.tnew)};
            w_dst_q <= m_q.dst;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] md_stall_cnt_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
            if (md_stall) md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    assign stall_cnt    = 32'd0;
    assign md_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a ready-time reference model.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_is_md, md_start_e, md_is_div;
    logic        stall, bubble_e;
    logic [1:0]  sign_rd1src, sign_rd2src, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt, md_stall_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_is_md(d_is_md),
        .md_start_e(md_start_e), .md_is_div(md_is_div),
        .stall(stall), .bubble_e(bubble_e),
        .sign_rd1src(sign_rd1src), .sign_rd2src(sign_rd2src),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
    );

    // Reference model: each in-flight instruction carries the absolute cycle
    // at which its result exists; age 0 = E, age 1 = M, age 2 = W.
    typedef struct {
        int rs;
        int rt;
        int dst;
        int ready;
    } ins_t;

    ins_t fl[3];
    int   now      = 0;
    int   md_until = -1;
    int   n_stall  = 0;
    int   n_mds    = 0;

    function automatic ins_t bub();
        ins_t b;
        b.rs = 0; b.rt = 0; b.dst = 0; b.ready = 0;
        return b;
    endfunction

    function automatic bit m_src_stall(int a, int tuse);
        if (tuse == 3 || a == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (fl[k].dst == a && (fl[k].ready - now) > tuse) return 1;
        return 0;
    endfunction

    function automatic bit m_md_stall();
        return d_is_md && (md_start_e || now <= md_until);
    endfunction

    function automatic bit m_stall();
        return m_src_stall(int'(d_rs), int'(d_tuse_rs)) || m_src_stall(int'(d_rt), int'(d_tuse_rt)) || m_md_stall();
    endfunction

    function automatic int m_dsel(int a);
        if (a == 0) return 3;
        for (int k = 0; k < 2; k++)
            if (fl[k].dst == a && fl[k].ready <= now) return k + 1;
        return 0;
    endfunction

    function automatic int m_efwd(int a);
        if (a == 0) return 0;
        if (fl[1].dst == a && fl[1].ready <= now) return 1;
        if (fl[2].dst == a) return 2;
        return 0;
    endfunction

    task automatic drive(input int rs, input int rt, input int trs, input int trt,
                         input int dst, input int tnew, input int ismd, input int st, input int isdiv);
        d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
        d_dst = 5'(dst); d_tnew = 2'(tnew); d_is_md = 1'(ismd);
        md_start_e = 1'(st); md_is_div = 1'(isdiv);
        #1;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit   s;
        bit   ms;
        ins_t n;
        s  = m_stall();
        ms = m_md_stall();
        n.rs = int'(d_rs); n.rt = int'(d_rt); n.dst = int'(d_dst);
        n.ready = now + 1 + int'(d_tnew);
        @(posedge clk);
        if (!reset) begin
            fl[0] = bub(); fl[1] = bub(); fl[2] = bub();
            md_until = -1; n_stall = 0; n_mds = 0;
        end else begin
            fl[2] = fl[1];
            fl[1] = fl[0];
            fl[0] = s ? bub() : n;
            if (md_start_e) md_until = now + (md_is_div ? DIV_N : MULT_N);
            if (s)  n_stall++;
            if (ms) n_mds++;
        end
        now++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall); end
        checks++; if (bubble_e !== 1'b0) begin fails++; $display("FAIL reset_bubble got %0d want 0", bubble_e); end
        checks++; if (sign_rd1src !== 2'd3) begin fails++; $display("FAIL reset_rd1src got %0d want 3", sign_rd1src); end
        checks++; if (sign_rd2src !== 2'd3) begin fails++; $display("FAIL reset_rd2src got %0d want 3", sign_rd2src); end
        checks++; if (fwd_rs_e !== 2'd0 || fwd_rt_e !== 2'd0) begin fails++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_rs_e, fwd_rt_e); end
        checks++; if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", stall_cnt, md_stall_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(0, 0, 3, 3, 1, 1, 0, 0, 0);            // addu $1
        tick();
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0);            // beq $1,$0
        checks++; if (stall !== 1'b1 || bubble_e !== 1'b1) begin fails++; $display("FAIL alu_branch_stall got %0d/%0d want 1/1", stall, bubble_e); end
        tick();
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_branch_release got %0d want 0", stall); end
        checks++; if (sign_rd1src !== 2'd2) begin fails++; $display("FAIL alu_branch_rd1src got %0d want 2", sign_rd1src); end
        checks++; if (sign_rd2src !== 2'd3) begin fails++; $display("FAIL alu_branch_rd2src got %0d want 3", sign_rd2src); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 0, 3, 3, 1, 2, 0, 0, 0);            // lw $1
        tick();
        drive(1, 3, 1, 1, 2, 1, 0, 0, 0);            // addu $2,$1,$3
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got %0d want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release got %0d want 0", stall); end
        checks++; if (sign_rd1src !== 2'd0) begin fails++; $display("FAIL load_use_rd1src got %0d want 0", sign_rd1src); end
        tick();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        checks++; if (fwd_rs_e !== 2'd2) begin fails++; $display("FAIL load_use_fwd_rs got %0d want 2", fwd_rs_e); end
        checks++; if (fwd_rt_e !== 2'd0) begin fails++; $display("FAIL load_use_fwd_rt got %0d want 0", fwd_rt_e); end
    endtask

    task automatic test_jal();
        do_reset();
        drive(0, 0, 3, 3, 31, 0, 0, 0, 0);           // jal
        tick();
        drive(31, 0, 0, 3, 0, 0, 0, 0, 0);           // jr $31
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL jal_stall got %0d want 0", stall); end
        checks++; if (sign_rd1src !== 2'd1) begin fails++; $display("FAIL jal_rd1src got %0d want 1", sign_rd1src); end
        drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
        checks++; if (sign_rd1src !== 2'd3 || stall !== 1'b0) begin fails++; $display("FAIL jal_zero got %0d/%0d want 3/0", sign_rd1src, stall); end
    endtask

    task automatic test_md(input int isdiv, input int want);
        int n;
        do_reset();
        n = 0;
        drive(0, 0, 3, 3, 0, 0, 1, 1, isdiv);        // mflo in D, mult/div issuing in E
        for (int i = 0; i < 20; i++) begin
            if (stall !== 1'b1) break;
            n++;
            tick();
            drive(0, 0, 3, 3, 0, 0, 1, 0, 0);
        end
        checks++; if (n != want) begin fails++; $display("FAIL md_%s_cycles got %0d want %0d", isdiv ? "div" : "mult", n, want); end
    endtask

    task automatic test_reset_during_md();
        do_reset();
        drive(0, 0, 3, 3, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        tick(); tick(); tick();                      // counter now at 7
        drive(1, 0, 3, 3, 0, 0, 1, 0, 0);
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL md_busy_before_reset got %0d want 1", stall); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(1, 2, 0, 0, 0, 0, 1, 0, 0);
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL md_reset_stall got %0d want 0", stall); end
        checks++; if (sign_rd1src !== 2'd0 || sign_rd2src !== 2'd0) begin fails++; $display("FAIL md_reset_dsel got %0d/%0d want 0/0", sign_rd1src, sign_rd2src); end
        checks++; if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin fails++; $display("FAIL md_reset_perf got %0d/%0d want 0/0", stall_cnt, md_stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
            checks++; if (stall !== 1'(m_stall())) begin fails++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, stall, m_stall()); end
            checks++; if (bubble_e !== 1'(m_stall())) begin fails++; $display("FAIL rnd_bubble cyc %0d got %0d want %0d", i, bubble_e, m_stall()); end
            checks++; if (sign_rd1src !== 2'(m_dsel(int'(d_rs)))) begin fails++; $display("FAIL rnd_rd1src cyc %0d got %0d want %0d", i, sign_rd1src, m_dsel(int'(d_rs))); end
            checks++; if (sign_rd2src !== 2'(m_dsel(int'(d_rt)))) begin fails++; $display("FAIL rnd_rd2src cyc %0d got %0d want %0d", i, sign_rd2src, m_dsel(int'(d_rt))); end
            checks++; if (fwd_rs_e !== 2'(m_efwd(fl[0].rs))) begin fails++; $display("FAIL rnd_fwd_rs cyc %0d got %0d want %0d", i, fwd_rs_e, m_efwd(fl[0].rs)); end
            checks++; if (fwd_rt_e !== 2'(m_efwd(fl[0].rt))) begin fails++; $display("FAIL rnd_fwd_rt cyc %0d got %0d want %0d", i, fwd_rt_e, m_efwd(fl[0].rt)); end
`ifdef HAZARD_PERF_EN
            checks++; if (stall_cnt !== 32'(n_stall)) begin fails++; $display("FAIL rnd_stall_cnt cyc %0d got %0d want %0d", i, stall_cnt, n_stall); end
            checks++; if (md_stall_cnt !== 32'(n_mds)) begin fails++; $display("FAIL rnd_md_stall_cnt cyc %0d got %0d want %0d", i, md_stall_cnt, n_mds); end
`else
            checks++; if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin fails++; $display("FAIL rnd_perf_off cyc %0d got %0d/%0d want 0/0", i, stall_cnt, md_stall_cnt); end
`endif
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        fl[0] = bub(); fl[1] = bub(); fl[2] = bub();
        reset = 1'b0;
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_branch();
        test_load_use();
        test_jal();
        test_md(1, DIV_N + 1);
        test_md(0, MULT_N + 1);
        test_reset_during_md();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
